// File: rtl/arb_pkg.sv
// Shared types and helpers for the 8-way round-robin arbiter.
// onehot_to_idx mirrors the downstream 8-to-3 encoder's mapping.
package arb_pkg;

   localparam int ARB_N     = 8;
   localparam int ARB_IDX_W = 3;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } arb_state_e;

   // OR-tree encoder, identical to the downstream stage for one-hot inputs
   function automatic logic [ARB_IDX_W-1:0] onehot_to_idx(input logic [ARB_N-1:0] oh);
      logic [ARB_IDX_W-1:0] idx;
      idx[0] = oh[1] | oh[3] | oh[5] | oh[7];
      idx[1] = oh[2] | oh[3] | oh[6] | oh[7];
      idx[2] = oh[4] | oh[5] | oh[6] | oh[7];
      return idx;
   endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational rotating priority search: first set bit of eff at or after
// start (wrapping 7->0) wins. Output is one-hot, or zero when eff is zero.
module rr_pick8
   import arb_pkg::*;
(
   input  logic [ARB_N-1:0]     eff,
   input  logic [ARB_IDX_W-1:0] start,
   output logic [ARB_N-1:0]     onehot
);

   always_comb begin
      logic                 found;
      logic [ARB_IDX_W-1:0] idx;
      onehot = '0;
      found  = 1'b0;
      idx    = '0;
      for (int k = 0; k < ARB_N; k++) begin
         idx = start + ARB_IDX_W'(k);
         if (eff[idx] && !found) begin
            onehot[idx] = 1'b1;
            found       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_arbiter8.sv
// Registered 8-way round-robin arbiter with valid/ready handshake; the grant
// is held without retraction until accepted, then re-searched the same cycle.
module rr_arbiter8
   import arb_pkg::*;
#(
   parameter int              N_REQ   = 8,
   parameter logic [2:0]      RST_PTR = 3'd7
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [ARB_N-1:0]     req,
   input  logic [ARB_N-1:0]     req_mask,
   output logic [ARB_N-1:0]     gnt,
   output logic                 gnt_valid,
   input  logic                 gnt_ready,
   output logic [ARB_IDX_W-1:0] last_ptr
);

   if (N_REQ != ARB_N) begin : g_bad_n_req
      $error("rr_arbiter8: N_REQ must be 8 to match the encoder width");
   end

   arb_state_e           state_q, state_d;
   logic [ARB_N-1:0]     gnt_q, gnt_d;
   logic [ARB_IDX_W-1:0] last_ptr_q, last_ptr_d;

   logic [ARB_N-1:0]     eff, pick;
   logic [ARB_IDX_W-1:0] gnt_idx, start;
   logic                 hs;

   assign eff     = req & req_mask;
   assign gnt_idx = onehot_to_idx(gnt_q);
   assign hs      = (state_q == ARB_GRANT) && gnt_ready;
   // On accept, search from the just-granted index so back-to-back grants
   // see the updated pointer without a bubble cycle.
   assign start   = (hs ? gnt_idx : last_ptr_q) + 3'd1;

   rr_pick8 u_pick (
      .eff    (eff),
      .start  (start),
      .onehot (pick)
   );

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      last_ptr_d = last_ptr_q;
      unique case (state_q)
         ARB_IDLE: begin
            if (eff != '0) begin
               gnt_d   = pick;
               state_d = ARB_GRANT;
            end
         end
         ARB_GRANT: begin
            if (hs) begin
               last_ptr_d = gnt_idx;
               gnt_d      = pick;
               state_d    = (eff != '0) ? ARB_GRANT : ARB_IDLE;
            end
         end
         default: begin
            state_d = ARB_IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ARB_IDLE;
         gnt_q      <= '0;
         last_ptr_q <= RST_PTR;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         last_ptr_q <= last_ptr_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_valid = (state_q == ARB_GRANT);
   assign last_ptr  = last_ptr_q;

   a_gnt_onehot: assert property (@(posedge clk) disable iff (rst)
      (gnt_valid == (gnt != '0)) && $onehot0(gnt));

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed checks for rr_arbiter8: reset, rotation, backpressure, wrap,
// masking, single requester and drain-to-idle.
module tb_rr_arbiter8;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req, req_mask, gnt;
   logic       gnt_valid, gnt_ready;
   logic [2:0] last_ptr;

   int checks = 0;
   int errors = 0;

   rr_arbiter8 dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_mask  (req_mask),
      .gnt       (gnt),
      .gnt_valid (gnt_valid),
      .gnt_ready (gnt_ready),
      .last_ptr  (last_ptr)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req = 8'h00; req_mask = 8'hFF; gnt_ready = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 8'h00; req_mask = 8'hFF; gnt_ready = 1'b0;
      #2;
      checks++;
      if (gnt !== 8'h00 || gnt_valid !== 1'b0 || last_ptr !== 3'd7) begin
         errors++;
         $display("FAIL reset_init: gnt=%h valid=%b ptr=%0d, want 00/0/7", gnt, gnt_valid, last_ptr);
      end
      step();
      rst = 1'b0;
      req = 8'h10;
      step();
      checks++;
      if (gnt !== 8'h10 || gnt_valid !== 1'b1) begin
         errors++;
         $display("FAIL reset_pre_grant: gnt=%h valid=%b, want 10/1", gnt, gnt_valid);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (gnt !== 8'h00 || gnt_valid !== 1'b0 || last_ptr !== 3'd7) begin
         errors++;
         $display("FAIL reset_mid_grant: gnt=%h valid=%b ptr=%0d, want 00/0/7", gnt, gnt_valid, last_ptr);
      end
      step();
      rst = 1'b0;
      req = 8'hFF;
      step();
      checks++;
      if (gnt !== 8'h01 || gnt_valid !== 1'b1) begin
         errors++;
         $display("FAIL reset_first_grant: gnt=%h valid=%b, want 01/1", gnt, gnt_valid);
      end
   endtask

   task automatic test_rotation();
      logic [7:0] exp_g;
      logic [2:0] exp_p;
      do_reset();
      req = 8'hFF; req_mask = 8'hFF; gnt_ready = 1'b1;
      for (int k = 0; k < 9; k++) begin
         step();
         exp_g = 8'h01 << (k % 8);
         exp_p = (k == 0) ? 3'd7 : 3'(k - 1);
         checks++;
         if (gnt !== exp_g || last_ptr !== exp_p || gnt_valid !== 1'b1) begin
            errors++;
            $display("FAIL rotation[%0d]: gnt=%h ptr=%0d valid=%b, want %h/%0d/1", k, gnt, last_ptr, gnt_valid, exp_g, exp_p);
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      req = 8'h24; gnt_ready = 1'b0;
      step();
      checks++;
      if (gnt !== 8'h04 || gnt_valid !== 1'b1) begin
         errors++;
         $display("FAIL bp_first: gnt=%h valid=%b, want 04/1", gnt, gnt_valid);
      end
      req = 8'h20;
      for (int k = 0; k < 5; k++) begin
         step();
         checks++;
         if (gnt !== 8'h04 || gnt_valid !== 1'b1 || last_ptr !== 3'd7) begin
            errors++;
            $display("FAIL bp_hold[%0d]: gnt=%h valid=%b ptr=%0d, want 04/1/7", k, gnt, gnt_valid, last_ptr);
         end
      end
      gnt_ready = 1'b1;
      step();
      gnt_ready = 1'b0;
      checks++;
      if (gnt !== 8'h20 || last_ptr !== 3'd2 || gnt_valid !== 1'b1) begin
         errors++;
         $display("FAIL bp_release: gnt=%h ptr=%0d valid=%b, want 20/2/1", gnt, last_ptr, gnt_valid);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      req = 8'h40; gnt_ready = 1'b1;
      step();
      req = 8'h41;
      step();
      checks++;
      if (gnt !== 8'h01 || last_ptr !== 3'd6) begin
         errors++;
         $display("FAIL wrap: gnt=%h ptr=%0d, want 01/6", gnt, last_ptr);
      end
      step();
      gnt_ready = 1'b0;
      checks++;
      if (gnt !== 8'h40 || last_ptr !== 3'd0) begin
         errors++;
         $display("FAIL wrap_next: gnt=%h ptr=%0d, want 40/0", gnt, last_ptr);
      end
   endtask

   task automatic test_mask();
      logic [7:0] exp_g;
      do_reset();
      req = 8'hFF; req_mask = 8'h88; gnt_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         exp_g = (k % 2 == 0) ? 8'h08 : 8'h80;
         checks++;
         if (gnt !== exp_g || gnt_valid !== 1'b1) begin
            errors++;
            $display("FAIL mask[%0d]: gnt=%h valid=%b, want %h/1", k, gnt, gnt_valid, exp_g);
         end
      end
      req_mask = 8'h00;
      step();
      checks++;
      if (gnt !== 8'h00 || gnt_valid !== 1'b0 || last_ptr !== 3'd7) begin
         errors++;
         $display("FAIL mask_off: gnt=%h valid=%b ptr=%0d, want 00/0/7", gnt, gnt_valid, last_ptr);
      end
      req_mask = 8'hFF;
   endtask

   task automatic test_single();
      do_reset();
      req = 8'h10; gnt_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         checks++;
         if (gnt !== 8'h10 || gnt_valid !== 1'b1 || last_ptr !== ((k == 0) ? 3'd7 : 3'd4)) begin
            errors++;
            $display("FAIL single[%0d]: gnt=%h valid=%b ptr=%0d, want 10/1/%0d", k, gnt, gnt_valid, last_ptr, (k == 0) ? 7 : 4);
         end
      end
   endtask

   task automatic test_drain();
      do_reset();
      req = 8'h02; gnt_ready = 1'b1;
      step();
      req = 8'h00;
      checks++;
      if (gnt !== 8'h02 || gnt_valid !== 1'b1 || arb_pkg::onehot_to_idx(gnt) !== 3'b001) begin
         errors++;
         $display("FAIL drain_grant: gnt=%h valid=%b, want 02/1 (index 1)", gnt, gnt_valid);
      end
      step();
      checks++;
      if (gnt !== 8'h00 || gnt_valid !== 1'b0 || last_ptr !== 3'd1) begin
         errors++;
         $display("FAIL drain_idle: gnt=%h valid=%b ptr=%0d, want 00/0/1", gnt, gnt_valid, last_ptr);
      end
      step();
      checks++;
      if (gnt_valid !== 1'b0 || last_ptr !== 3'd1) begin
         errors++;
         $display("FAIL idle_ready_ignored: valid=%b ptr=%0d, want 0/1", gnt_valid, last_ptr);
      end
   endtask

   initial begin
      test_reset();
      test_rotation();
      test_backpressure();
      test_wrap();
      test_mask();
      test_single();
      test_drain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Registered 8-way round-robin arbiter with valid/ready output handshake.
- Sits directly upstream of the 8-to-3 encoder stage. Its one-hot grant vector drives the encoder's 8-bit input, and the encoder's 3-bit output is the granted index.
- Guarantees the grant vector is exactly one-hot whenever valid and all-zero otherwise, so the encoder never sees an invalid code.

Parameters:
- N_REQ, 8, number of requesters. Fixed at 8 to match encoder width; any other value is an elaboration error.
- RST_PTR, 7, reset value of the last-granted pointer (0..7). Default gives requester 0 first priority.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req  input  8  request lines, level-sensitive, bit i = requester i
- req_mask  input  8  1 = requester enabled; masked bits ignored
- gnt  output  8  registered one-hot grant (encoder d input); 0 when not valid
- gnt_valid  output  1  grant vector holds a committed grant
- gnt_ready  input  1  downstream accepts grant this cycle
- last_ptr  output  3  index of most recently accepted grant (debug/observe)

Behaviour:
- Reset (async assert, sync-release by the system):
  - gnt = 8'h00, gnt_valid = 0, last_ptr = RST_PTR.
  - State = IDLE.
- Effective request: eff = req & req_mask.
- Priority search order, combinational:
  - Start at (last_ptr+1) mod 8, wrapping through 7→0.
  - First set bit of eff wins; result is one-hot or zero.
- States:
  - IDLE: gnt_valid = 0.
    - If eff != 0: load gnt = search result, gnt_valid = 1, go to GRANT on the next edge.
    - Latency is 1 cycle from req to gnt_valid.
  - GRANT: gnt_valid = 1; gnt held stable while gnt_ready = 0.
    - On handshake (gnt_valid & gnt_ready):
      - last_ptr ← index of gnt (3-bit, via the same one-hot → index mapping as the downstream encoder).
      - Next grant is searched with the updated pointer, i.e. starting at granted index+1. Implement this as a combinational search from granted index+1, without waiting a cycle.
      - If eff != 0: load the new gnt and stay in GRANT (back-to-back grants, one per cycle at full throughput).
      - Else: gnt = 0, gnt_valid = 0, go to IDLE.
- No retraction: once gnt_valid = 1, gnt must not change until handshake, even if the granted req or req_mask bit drops.
- A newly arriving higher-priority request never preempts a pending grant.
- Single requester continuously asserted: re-granted every handshake (pointer wraps to itself).
- All 8 requesters continuously asserted: grants cycle 0,1,…,7,0 with no requester skipped or repeated within 8 accepts.
- gnt_ready while gnt_valid = 0: ignored; no pointer update.
- Reset mid-GRANT: pending grant discarded immediately (async); no handshake is reported.
- Invariant (assertion): gnt_valid == (gnt != 0) and $onehot0(gnt) at every clock.

Decomposition:
- Shared package (arb_pkg):
  - ARB_N = 8, ARB_IDX_W = 3.
  - state enum {ARB_IDLE, ARB_GRANT}.
  - Function onehot_to_idx (8→3, matching encoder mapping).
- One natural sub-module: rr_pick8.
  - Purely combinational rotate-search: inputs eff[7:0], start[2:0]; output onehot[7:0].
  - Instantiated once for the next-grant search.

Test Plan:
- Reset: assert rst mid-GRANT with gnt = 8'h10 → gnt = 0, gnt_valid = 0, last_ptr = 7 within the same cycle. After release, req = 8'hFF → gnt = 8'h01 one cycle later.
- Full rotation: req = 8'hFF, mask = 8'hFF, gnt_ready = 1 constantly → gnt sequence 01,02,04,08,10,20,40,80,01 on consecutive cycles; last_ptr 0..7,0.
- Backpressure/no-retraction: req = 8'h24, gnt = 8'h04 (from last_ptr = 7); hold gnt_ready = 0 for 5 cycles while dropping req to 8'h20 → gnt stays 8'h04. Then ready = 1 → next gnt = 8'h20, last_ptr = 2.
- Wrap and sparse: last_ptr = 6, req = 8'h41 → gnt = 8'h01 (bit 7 empty, wraps). After accept, next gnt = 8'h40.
- Masking: req = 8'hFF, req_mask = 8'h88 → grants alternate 8'h08, 8'h80 only. req_mask = 8'h00 → gnt_valid = 0, state IDLE after the current handshake.
- Drain to idle: single req = 8'h02 pulsed one cycle, ready = 1 → gnt = 8'h02 for one cycle, then gnt = 0, gnt_valid = 0; encoder downstream reads 3'b001 during the valid cycle.
